dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder for the RV32 core's split read/write dmem interface: the memory-side end of the `dmem_*` handshake that `top` exports. It owns a word-addressed byte-writable SRAM array and accepts read/write requests. Each path has a programmable wait-state generator, either fixed or pseudo-random, for stall-coverage testing. Reads return registered data and a response flag one cycle after acceptance. Sits beside `top` in the SoC/testbench, on the external `dmem_*` ports.

## Interface
- `AW`, 14: word-address width; array holds 2**AW 32-bit words.
- `BASE`, 4'h0: value `addr[31:28]` must match for an access to hit this block.
- `RWAIT`, 0: read wait states (fixed) or maximum wait states (random), 0..15.
- `WWAIT`, 0: write wait states, same semantics as `RWAIT`.
- `RAND`, 0: 1 = per-transaction wait count drawn from LFSR; 0 = fixed.

Ports:
- `clk` in 1: clock. One clock domain.
- `resetb` in 1: reset, asynchronous, active-low.
- `dmem_wready` in 1: write request from core.
- `dmem_wvalid` out 1: write accepted this cycle.
- `dmem_waddr` in 32: write byte address (`[1:0]` ignored).
- `dmem_wdata` in 32: write data.
- `dmem_wstrb` in 4: byte enables; bit i controls `wdata[8i+7:8i]`.
- `dmem_rready` in 1: read request from core.
- `dmem_rvalid` out 1: read accepted this cycle.
- `dmem_raddr` in 32: read byte address (`[1:0]` ignored).
- `dmem_rresp` out 1: 1 = last accepted read hit; 0 = out of range.
- `dmem_rdata` out 32: data of last accepted read.

## Operation
- Hit: `addr[31:28]==BASE` and `addr[27:2] < 2**AW`; word index is `addr[AW+1:2]`.
- Wait counter per path: `cnt` (4 bit) counts consecutive request cycles without acceptance.
  - `valid = ready && (cnt == tgt)`, combinational from registers.
  - `cnt` increments while `ready && !valid`; clears on accept or when `ready` falls (a withdrawn request restarts).
- Target selection:
  - `tgt` = WAIT when `RAND=0`.
  - When `RAND=1`: `tgt` = `lfsr[3:0] % (WAIT+1)`, reloaded at each accept of that path.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11; seed 16'hACE1 for read, 16'h1D2B for write. It advances one step per accept.
- Write accept: on hit, bytes with strobe set are written at the clock edge. On miss, the write is dropped silently. `dmem_wvalid` still asserts.
- Read accept, registered on the same edge:
  - On hit: `dmem_rdata` = array word and `dmem_rresp` = 1.
  - On miss: `dmem_rdata` = 0 and `dmem_rresp` = 0.
- Same-cycle read and write accept to the same word: the read returns the merged value. Strobed bytes come from `wdata`, the others from the old array contents (write-first, per byte).
- `dmem_rdata`/`dmem_rresp` hold until the next read accept.
- Array contents are not reset and are undefined after power-up.

## Timing
- Reset values: `dmem_rdata`=0, `dmem_rresp`=1, both `cnt`=0, LFSRs=seed, `tgt`=fixed WAIT or seed-derived.
  - `dmem_wvalid`/`dmem_rvalid` are then 0 unless the matching ready is high and `tgt`=0.
- WAIT=0: accept in the same cycle ready rises (combinational ready->valid path).
- WAIT=N: accept on the (N+1)th consecutive ready cycle.
- Read data latency: 1 cycle after the accept cycle.
- Back-to-back accepts: with `tgt`=0, one read and one write per cycle, sustained.
- Core holds address/data stable while ready is high and not accepted. Changes before accept are not tracked; data is sampled at the accept edge.
- Reset mid-wait: counters clear immediately, no accept occurs, and no array write occurs.

## Structure
- Shared package: `DMEM_LFSR_TAPS`, the two seeds, and the `BASE` nibble constants alongside `CLINT_BASE`.
- Sub-module `dmem_wait` (parameters WAIT, RAND, SEED; ports clk, resetb, ready, valid) holds the counter, LFSR and target. It is instantiated once per path.
- The array is inferred as four byte lanes of 2**AW x 8.

## Test plan
- **Fixed latency, no waits:** RWAIT=0, WWAIT=0. Write 0xDEADBEEF to 0x100 with strobe 4'hF, then read 0x100. Required: `wvalid` in the request cycle, `rvalid` in the request cycle, `rdata`=0xDEADBEEF and `rresp`=1 one cycle later.
- **Partial strobe:** after the above, write 0x11223344 to 0x100 with strobe 4'b0101, then read. Required: `rdata`=0xDE22BE44.
- **Fixed waits:** RWAIT=3. Hold `rready`. Required: `rvalid` is 0 for 3 cycles and 1 on the 4th. Drop `rready` after 2 cycles and re-raise it: 4 further cycles are required before accept.
- **Out of range:** AW=10. Read 0x00001000. Required: `rresp`=0, `rdata`=0. A write to the same address is accepted and leaves word 0 unchanged.
- **Collision:** word 0x40 holds 0xAAAAAAAA. Same-cycle write 0x55555555 with strobe 4'b0011 and read of 0x40. Required: `rdata`=0xAAAA5555.
- **Random mode:** RAND=1, RWAIT=7, 1000 reads. Required: every wait count is 0..7, all 8 values occur, reset mid-wait produces no accept, and data matches a reference model.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// Shared constants and helpers for the dmem responder and its wait-state generators.
package dmem_resp_pkg;

  localparam int unsigned DMEM_LFSR_W = 16;
  localparam int unsigned DMEM_CNT_W  = 4;

  // Fibonacci taps 16,14,13,11 expressed as a right-shift feedback mask
  localparam logic [DMEM_LFSR_W-1:0] DMEM_LFSR_TAPS = 16'h002D;
  localparam logic [DMEM_LFSR_W-1:0] DMEM_RSEED     = 16'hACE1;
  localparam logic [DMEM_LFSR_W-1:0] DMEM_WSEED     = 16'h1D2B;

  // Address-map nibbles (addr[31:28])
  localparam logic [3:0] DMEM_BASE  = 4'h0;
  localparam logic [3:0] CLINT_BASE = 4'h2;

  // Registered read response
  typedef struct packed {
    logic [31:0] data;
    logic        resp;
  } rd_resp_t;

  // One LFSR step: feedback enters at the MSB, register shifts right
  function automatic logic [DMEM_LFSR_W-1:0] lfsr_step(input logic [DMEM_LFSR_W-1:0] s);
    return {^(s & DMEM_LFSR_TAPS), s[DMEM_LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/dmem_wait.sv
// Wait-state generator for one request path: counts stalled request cycles
// and accepts once the count reaches a fixed or LFSR-drawn target.
module dmem_wait
  import dmem_resp_pkg::*;
#(
  parameter int unsigned           WAIT = 0,
  parameter int unsigned           RAND = 0,
  parameter logic [DMEM_LFSR_W-1:0] SEED = DMEM_RSEED
) (
  input  logic clk,
  input  logic resetb,
  input  logic ready,
  output logic valid
);

  localparam logic [4:0] MOD = 5'(WAIT + 1);

  logic [DMEM_CNT_W-1:0]  cnt;
  logic [DMEM_CNT_W-1:0]  tgt;
  logic [DMEM_LFSR_W-1:0] lfsr;

  // Target follows the LFSR in random mode; accept is gated off during reset
  always_comb begin
    tgt = DMEM_CNT_W'(WAIT);
    if (RAND != 0) begin
      tgt = DMEM_CNT_W'({1'b0, lfsr[3:0]} % MOD);
    end
    valid = resetb && ready && (cnt == tgt);
  end

  // Stall counter: restarts on accept or when the request is withdrawn
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (ready && !valid) begin
      cnt <= cnt + DMEM_CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // LFSR advances once per accepted transaction
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      lfsr <= SEED;
    end else if (valid) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Memory-side responder for the core's split read/write dmem interface.
// Byte-writable SRAM with programmable wait states on each path.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned AW    = 14,
  parameter logic [3:0]  BASE  = DMEM_BASE,
  parameter int unsigned RWAIT = 0,
  parameter int unsigned WWAIT = 0,
  parameter int unsigned RAND  = 0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        dmem_wready,
  output logic        dmem_wvalid,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  input  logic        dmem_rready,
  output logic        dmem_rvalid,
  input  logic [31:0] dmem_raddr,
  output logic        dmem_rresp,
  output logic [31:0] dmem_rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic          whit;
  logic          rhit;
  logic [AW-1:0] widx;
  logic [AW-1:0] ridx;
  logic          wen;
  logic          fwd;
  logic [31:0]   rword;
  rd_resp_t      rd;
  logic          unused_lsbs;

  dmem_wait #(.WAIT(WWAIT), .RAND(RAND), .SEED(DMEM_WSEED)) u_wwait (
    .clk    (clk),
    .resetb (resetb),
    .ready  (dmem_wready),
    .valid  (dmem_wvalid)
  );

  dmem_wait #(.WAIT(RWAIT), .RAND(RAND), .SEED(DMEM_RSEED)) u_rwait (
    .clk    (clk),
    .resetb (resetb),
    .ready  (dmem_rready),
    .valid  (dmem_rvalid)
  );

  // Address decode: region nibble plus word index inside the array
  assign whit = (dmem_waddr[31:28] == BASE) && ((dmem_waddr[27:2] >> AW) == 26'd0);
  assign rhit = (dmem_raddr[31:28] == BASE) && ((dmem_raddr[27:2] >> AW) == 26'd0);
  assign widx = dmem_waddr[AW+1:2];
  assign ridx = dmem_raddr[AW+1:2];
  assign wen  = dmem_wvalid && whit;
  // Same-cycle write to the read word: strobed bytes bypass to the read port
  assign fwd  = wen && rhit && (ridx == widx);
  assign unused_lsbs = ^{dmem_waddr[1:0], dmem_raddr[1:0]};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH];

    // Byte-lane write, no reset on the array
    always_ff @(posedge clk) begin
      if (wen && dmem_wstrb[i]) begin
        mem[widx] <= dmem_wdata[8*i +: 8];
      end
    end

    assign rword[8*i +: 8] = (fwd && dmem_wstrb[i]) ? dmem_wdata[8*i +: 8] : mem[ridx];
  end

  // Read response register, updated only on read accept
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd <= '{data: 32'h0, resp: 1'b1};
    end else if (dmem_rvalid) begin
      if (rhit) begin
        rd <= '{data: rword, resp: 1'b1};
      end else begin
        rd <= '{data: 32'h0, resp: 1'b0};
      end
    end
  end

  assign dmem_rdata = rd.data;
  assign dmem_rresp = rd.resp;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench: instance A (no waits), C (fixed waits), B (random waits).
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        resetb;
  logic [31:0] waddr, wdata, raddr;
  logic [3:0]  wstrb;

  logic a_wready, a_rready, a_wvalid, a_rvalid, a_rresp;
  logic b_wready, b_rready, b_wvalid, b_rvalid, b_rresp;
  logic c_wready, c_rready, c_wvalid, c_rvalid, c_rresp;
  logic [31:0] a_rdata, b_rdata, c_rdata;

  typedef struct {
    logic        resp;
    logic [31:0] data;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  logic a_pend = 1'b0;
  logic b_pend = 1'b0;
  logic [31:0] b_mem [64];
  logic [15:0] lfsr_m;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_resp #(.AW(10), .RWAIT(0), .WWAIT(0), .RAND(0)) u_a (
    .clk(clk), .resetb(resetb),
    .dmem_wready(a_wready), .dmem_wvalid(a_wvalid), .dmem_waddr(waddr),
    .dmem_wdata(wdata), .dmem_wstrb(wstrb),
    .dmem_rready(a_rready), .dmem_rvalid(a_rvalid), .dmem_raddr(raddr),
    .dmem_rresp(a_rresp), .dmem_rdata(a_rdata)
  );

  dmem_resp #(.AW(10), .RWAIT(7), .WWAIT(0), .RAND(1)) u_b (
    .clk(clk), .resetb(resetb),
    .dmem_wready(b_wready), .dmem_wvalid(b_wvalid), .dmem_waddr(waddr),
    .dmem_wdata(wdata), .dmem_wstrb(wstrb),
    .dmem_rready(b_rready), .dmem_rvalid(b_rvalid), .dmem_raddr(raddr),
    .dmem_rresp(b_rresp), .dmem_rdata(b_rdata)
  );

  dmem_resp #(.AW(10), .RWAIT(3), .WWAIT(2), .RAND(0)) u_c (
    .clk(clk), .resetb(resetb),
    .dmem_wready(c_wready), .dmem_wvalid(c_wvalid), .dmem_waddr(waddr),
    .dmem_wdata(wdata), .dmem_wstrb(wstrb),
    .dmem_rready(c_rready), .dmem_rvalid(c_rvalid), .dmem_raddr(raddr),
    .dmem_rresp(c_rresp), .dmem_rdata(c_rdata)
  );

  // Reference LFSR: taps 16,14,13,11, shifting right
  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // One cycle on instance A: compare last read, drive, check same-cycle accept
  task automatic a_cycle(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] ws, input logic rd, input logic [31:0] ra,
                         input logic er, input logic [31:0] ed);
    exp_t e;
    @(negedge clk);
    if (a_pend) begin
      e = a_q.pop_front();
      checks++;
      if (a_rresp !== e.resp) begin
        errors++;
        $display("FAIL a_rresp: got %b expected %b", a_rresp, e.resp);
      end
      checks++;
      if (a_rdata !== e.data) begin
        errors++;
        $display("FAIL a_rdata: got %h expected %h", a_rdata, e.data);
      end
      a_pend = 1'b0;
    end
    a_wready = wr; waddr = wa; wdata = wd; wstrb = ws;
    a_rready = rd; raddr = ra;
    #1;
    checks++;
    if (a_wvalid !== wr) begin
      errors++;
      $display("FAIL a_wvalid: got %b expected %b", a_wvalid, wr);
    end
    checks++;
    if (a_rvalid !== rd) begin
      errors++;
      $display("FAIL a_rvalid: got %b expected %b", a_rvalid, rd);
    end
    if (rd) begin
      e.resp = er;
      e.data = ed;
      a_q.push_back(e);
      a_pend = 1'b1;
    end
  endtask

  task automatic a_idle();
    a_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    a_wready = 0; a_rready = 0; b_wready = 0; b_rready = 0; c_wready = 0; c_rready = 0;
    waddr = 0; wdata = 0; wstrb = 0; raddr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
    checks++;
    if (a_rresp !== 1'b1) begin errors++; $display("FAIL reset_rresp: got %b expected 1", a_rresp); end
    checks++;
    if (c_rresp !== 1'b1) begin errors++; $display("FAIL reset_c_rresp: got %b expected 1", c_rresp); end
    checks++;
    if ({a_wvalid, a_rvalid, c_wvalid, c_rvalid} !== 4'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0000", {a_wvalid, a_rvalid, c_wvalid, c_rvalid});
    end
    resetb = 1'b1;
  endtask

  task automatic test_no_wait();
    a_cycle(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0);
    a_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h100, 1'b1, 32'hDEADBEEF);
    a_idle();
  endtask

  task automatic test_partial_strobe();
    a_cycle(1'b1, 32'h100, 32'h11223344, 4'b0101, 1'b0, 32'h0, 1'b0, 32'h0);
    a_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h100, 1'b1, 32'hDE22BE44);
    a_idle();
  endtask

  task automatic test_out_of_range();
    a_cycle(1'b1, 32'h0, 32'h01234567, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0);
    a_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1000, 1'b0, 32'h0);
    a_cycle(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h10000000, 1'b0, 32'h0);
    a_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 32'h01234567);
    a_idle();
  endtask

  task automatic test_collision();
    a_cycle(1'b1, 32'h40, 32'hAAAAAAAA, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0);
    a_cycle(1'b1, 32'h40, 32'h55555555, 4'b0011, 1'b1, 32'h40, 1'b1, 32'hAAAA5555);
    a_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h40, 1'b1, 32'hAAAA5555);
    a_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] m [16];
    logic [31:0] d;
    for (int i = 0; i <= 16; i++) begin
      d = $urandom;
      a_cycle(i < 16, 32'h200 + 32'(i) * 4, d, 4'hF,
              i > 0, 32'h200 + 32'(i - 1) * 4, 1'b1, (i > 0) ? m[(i + 15) % 16] : 32'h0);
      if (i < 16) m[i] = d;
    end
    a_idle();
  endtask

  task automatic test_fixed_wait();
    @(negedge clk);
    c_wready = 1'b1; waddr = 32'h80; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1; checks++;
      if (c_wvalid !== (k == 2)) begin errors++; $display("FAIL c_wvalid cyc%0d: got %b expected %b", k, c_wvalid, k == 2); end
      @(negedge clk);
    end
    c_wready = 1'b0;
    c_rready = 1'b1; raddr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      #1; checks++;
      if (c_rvalid !== (k == 3)) begin errors++; $display("FAIL c_rvalid cyc%0d: got %b expected %b", k, c_rvalid, k == 3); end
      @(negedge clk);
    end
    c_rready = 1'b0;
    checks++;
    if (c_rdata !== 32'hCAFEF00D || c_rresp !== 1'b1) begin
      errors++; $display("FAIL c_read: got %b/%h expected 1/cafef00d", c_rresp, c_rdata);
    end
    @(negedge clk);
    c_rready = 1'b1; raddr = 32'h1000;
    for (int k = 0; k < 2; k++) begin
      #1; checks++;
      if (c_rvalid !== 1'b0) begin errors++; $display("FAIL c_withdraw_pre cyc%0d: got %b expected 0", k, c_rvalid); end
      @(negedge clk);
    end
    c_rready = 1'b0;
    @(negedge clk);
    c_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1; checks++;
      if (c_rvalid !== (k == 3)) begin errors++; $display("FAIL c_restart cyc%0d: got %b expected %b", k, c_rvalid, k == 3); end
      @(negedge clk);
    end
    c_rready = 1'b0;
    checks++;
    if (c_rdata !== 32'h0 || c_rresp !== 1'b0) begin
      errors++; $display("FAIL c_miss: got %b/%h expected 0/00000000", c_rresp, c_rdata);
    end
  endtask

  task automatic b_pop();
    exp_t e;
    if (b_pend) begin
      e = b_q.pop_front();
      checks++;
      if (b_rresp !== e.resp || b_rdata !== e.data) begin
        errors++; $display("FAIL b_read: got %b/%h expected %b/%h", b_rresp, b_rdata, e.resp, e.data);
      end
      b_pend = 1'b0;
    end
  endtask

  task automatic test_random();
    exp_t e;
    int w;
    int idx;
    logic [7:0] seen;
    logic [31:0] ra;
    logic [2:0] ew;
    // fill: random-mode writes with WWAIT=0 always accept at once
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      b_wready = 1'b1; waddr = 32'(i) * 4; wdata = $urandom; wstrb = 4'hF;
      b_mem[i] = wdata;
      #1; checks++;
      if (b_wvalid !== 1'b1) begin errors++; $display("FAIL b_wvalid %0d: got %b expected 1", i, b_wvalid); end
    end
    @(negedge clk);
    b_wready = 1'b0;
    // reset in the middle of a wait: seed gives target 1
    b_rready = 1'b1; raddr = 32'h0;
    #1; checks++;
    if (b_rvalid !== 1'b0) begin errors++; $display("FAIL b_seed_wait: got %b expected 0", b_rvalid); end
    @(negedge clk);
    resetb = 1'b0;
    #1; checks++;
    if (b_rvalid !== 1'b0) begin errors++; $display("FAIL b_rst_valid: got %b expected 0", b_rvalid); end
    @(negedge clk);
    checks++;
    if (b_rvalid !== 1'b0 || b_rdata !== 32'h0 || b_rresp !== 1'b1) begin
      errors++; $display("FAIL b_rst_state: got %b/%b/%h expected 0/1/00000000", b_rvalid, b_rresp, b_rdata);
    end
    resetb = 1'b1;
    #1; checks++;
    if (b_rvalid !== 1'b0) begin errors++; $display("FAIL b_post_rst0: got %b expected 0", b_rvalid); end
    @(negedge clk);
    #1; checks++;
    if (b_rvalid !== 1'b1) begin errors++; $display("FAIL b_post_rst1: got %b expected 1", b_rvalid); end
    e.resp = 1'b1; e.data = b_mem[0];
    b_q.push_back(e); b_pend = 1'b1;
    lfsr_m = m_step(16'hACE1);
    // random wait sequence
    seen = 8'h0;
    for (int n = 0; n < 1000; n++) begin
      idx = $urandom_range(0, 63);
      ra = (n % 50 == 49) ? 32'h1000 + 32'(idx) * 4 : 32'(idx) * 4;
      @(negedge clk);
      b_pop();
      b_rready = 1'b1; raddr = ra;
      #1; w = 0;
      while (b_rvalid !== 1'b1 && w < 20) begin
        @(negedge clk); #1; w++;
      end
      ew = 3'(lfsr_m[3:0] % 4'd8);
      checks++;
      if (w !== int'(ew) || w > 7) begin
        errors++; $display("FAIL b_wait %0d: got %0d expected %0d", n, w, ew);
      end
      if (w < 8) seen[w] = 1'b1;
      if (w < 20) begin
        e.resp = (n % 50 != 49);
        e.data = (n % 50 != 49) ? b_mem[idx] : 32'h0;
        b_q.push_back(e); b_pend = 1'b1;
        lfsr_m = m_step(lfsr_m);
      end else begin
        b_rready = 1'b0;
      end
    end
    @(negedge clk);
    b_pop();
    b_rready = 1'b0;
    for (int v = 0; v < 8; v++) begin
      checks++;
      if (!seen[v]) begin errors++; $display("FAIL b_coverage: wait %0d got 0 hits expected >0", v); end
    end
  endtask

  task automatic test_reset_no_write();
    a_cycle(1'b1, 32'h300, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0);
    a_idle();
    @(negedge clk);
    resetb = 1'b0;
    a_wready = 1'b1; waddr = 32'h300; wdata = 32'h0; wstrb = 4'hF;
    @(negedge clk);
    a_wready = 1'b0;
    checks++;
    if (a_rdata !== 32'h0 || a_rresp !== 1'b1) begin
      errors++; $display("FAIL a_rst_state: got %b/%h expected 1/00000000", a_rresp, a_rdata);
    end
    resetb = 1'b1;
    a_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h300, 1'b1, 32'h12345678);
    a_idle();
  endtask

  initial begin
    test_reset();
    test_no_wait();
    test_partial_strobe();
    test_out_of_range();
    test_collision();
    test_back_to_back();
    test_fixed_wait();
    test_random();
    test_reset_no_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
